// File: rtl/switch_allocator_rr.sv
`default_nettype none
// ============================================================================
// Module  : switch_allocator_rr
// Brief   : Per-output round-robin allocator for the XY mesh switch crossbar.
//           Optional packet locking (wormhole) when PKT_LOCK_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
module switch_allocator_rr #(
  parameter int PORT_N     = 5,
  parameter int OUTPUT_N_W = 3
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [PORT_N-1:0]              req_valid_i,
  input  logic [PORT_N*OUTPUT_N_W-1:0]   req_sel_i,
  input  logic [PORT_N-1:0]              req_last_i,
  input  logic [PORT_N-1:0]              out_ready_i,
  output logic [PORT_N-1:0]              out_valid_o,
  output logic [PORT_N*OUTPUT_N_W-1:0]   xbar_sel_o,
  output logic [PORT_N-1:0]              grant_o
);

  // One extra bit so PORT_N itself is representable even when PORT_N == 2^W.
  localparam logic [OUTPUT_N_W:0] c_PORT_N_X = (OUTPUT_N_W+1)'(PORT_N);
  localparam logic [OUTPUT_N_W:0] c_LAST_IDX = (OUTPUT_N_W+1)'(PORT_N-1);

  logic [OUTPUT_N_W-1:0] r_ptr  [PORT_N];
  logic [OUTPUT_N_W-1:0] w_tgt  [PORT_N];
  logic [OUTPUT_N_W-1:0] w_win  [PORT_N];
  logic [OUTPUT_N_W-1:0] w_nxt  [PORT_N];
  logic [PORT_N-1:0]     w_elig [PORT_N];
  logic [PORT_N-1:0]     w_has;
  logic [PORT_N-1:0]     w_xfer;

`ifdef PKT_LOCK_EN
  logic [PORT_N-1:0]     r_lock_vld;
  logic [OUTPUT_N_W-1:0] r_lock_in [PORT_N];
  logic [PORT_N-1:0]     w_last;
`else
  logic                  w_unused_last;
  assign w_unused_last = ^req_last_i;
`endif

  // Out-of-range selects fall back to output 0, mirroring the router.
  always_comb begin
    for (int i = 0; i < PORT_N; i++) begin
      w_tgt[i] = req_sel_i[i*OUTPUT_N_W +: OUTPUT_N_W];
      if ({1'b0, w_tgt[i]} >= c_PORT_N_X) w_tgt[i] = '0;
    end
  end

  always_comb begin
    for (int o = 0; o < PORT_N; o++) begin
      for (int i = 0; i < PORT_N; i++) begin
        w_elig[o][i] = req_valid_i[i] && (w_tgt[i] == OUTPUT_N_W'(o));
`ifdef PKT_LOCK_EN
        if (r_lock_vld[o] && (r_lock_in[o] != OUTPUT_N_W'(i))) w_elig[o][i] = 1'b0;
`endif
      end
    end
  end

  always_comb begin
    logic [OUTPUT_N_W:0] w_idx;
    for (int o = 0; o < PORT_N; o++) begin
      w_has[o] = 1'b0;
      w_win[o] = '0;
      for (int k = 0; k < PORT_N; k++) begin
        w_idx = {1'b0, r_ptr[o]} + (OUTPUT_N_W+1)'(k);
        if (w_idx >= c_PORT_N_X) w_idx = w_idx - c_PORT_N_X;
        for (int i = 0; i < PORT_N; i++) begin
          if (!w_has[o] && (w_idx == (OUTPUT_N_W+1)'(i)) && w_elig[o][i]) begin
            w_has[o] = 1'b1;
            w_win[o] = OUTPUT_N_W'(i);
          end
        end
      end
      w_xfer[o] = w_has[o] & out_ready_i[o];
      w_nxt[o]  = ({1'b0, w_win[o]} == c_LAST_IDX) ? '0 : w_win[o] + 1'b1;
    end
  end

`ifdef PKT_LOCK_EN
  always_comb begin
    for (int o = 0; o < PORT_N; o++) begin
      w_last[o] = 1'b0;
      for (int i = 0; i < PORT_N; i++) begin
        if (w_win[o] == OUTPUT_N_W'(i)) w_last[o] = req_last_i[i];
      end
    end
  end
`endif

  always_comb begin
    out_valid_o = '0;
    xbar_sel_o  = '0;
    grant_o     = '0;
    for (int o = 0; o < PORT_N; o++) begin
      out_valid_o[o] = w_has[o];
      xbar_sel_o[o*OUTPUT_N_W +: OUTPUT_N_W] = w_win[o];
      for (int i = 0; i < PORT_N; i++) begin
        if (w_xfer[o] && (w_win[o] == OUTPUT_N_W'(i))) grant_o[i] = 1'b1;
      end
    end
  end

  // Priority only rotates on an actual transfer; back-pressure holds it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int o = 0; o < PORT_N; o++) begin
        r_ptr[o] <= '0;
`ifdef PKT_LOCK_EN
        r_lock_in[o]  <= '0;
        r_lock_vld[o] <= 1'b0;
`endif
      end
    end else begin
      for (int o = 0; o < PORT_N; o++) begin
        if (w_xfer[o]) begin
`ifdef PKT_LOCK_EN
          if (w_last[o]) begin
            r_ptr[o]      <= w_nxt[o];
            r_lock_vld[o] <= 1'b0;
          end else begin
            r_lock_vld[o] <= 1'b1;
            r_lock_in[o]  <= w_win[o];
          end
`else
          r_ptr[o] <= w_nxt[o];
`endif
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_switch_allocator_rr.sv
`default_nettype none
// Directed self-checking bench for switch_allocator_rr (PORT_N=5, OUTPUT_N_W=3).
module tb_switch_allocator_rr;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  req_valid;
  logic [14:0] req_sel;
  logic [4:0]  req_last;
  logic [4:0]  out_ready;
  logic [4:0]  out_valid;
  logic [14:0] xbar_sel;
  logic [4:0]  grant;

  int vectors = 0;
  int miscompares = 0;

  switch_allocator_rr #(.PORT_N(5), .OUTPUT_N_W(3)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_sel_i   (req_sel),
    .req_last_i  (req_last),
    .out_ready_i (out_ready),
    .out_valid_o (out_valid),
    .xbar_sel_o  (xbar_sel),
    .grant_o     (grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_sel   = '0;
    req_last  = '1;
    out_ready = '1;

    // Reset and idle
    #23;
    chk("rst_valid", 15'(out_valid), 15'h0);
    chk("rst_xbar", xbar_sel, 15'h0);
    chk("rst_grant", 15'(grant), 15'h0);
    rst_n = 1'b1;
    tick();
    chk("idle_valid", 15'(out_valid), 15'h0);
    chk("idle_grant", 15'(grant), 15'h0);

    // Fair rotation: all inputs to output 0, winners 0,1,2,3,4,0
    req_valid = 5'b11111;
    req_sel   = '0;
    #1;
    for (int k = 0; k < 6; k++) begin
      chk("rot_grant", 15'(grant), 15'(5'b00001 << (k % 5)));
      chk("rot_xbar", xbar_sel, 15'(k % 5));
      chk("rot_valid", 15'(out_valid), 15'h0001);
      tick();
    end

    // Back-pressure: inputs 1 and 3 to output 2
    req_valid = 5'b01010;
    req_sel   = {3'd0, 3'd2, 3'd0, 3'd2, 3'd0};
    out_ready = 5'b11011;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_valid", 15'(out_valid), 15'h0004);
      chk("bp_xbar", xbar_sel, 15'h0040);
      chk("bp_grant", 15'(grant), 15'h0);
      tick();
    end
    out_ready = 5'b11111;
    #1;
    chk("bp_release_grant", 15'(grant), 15'h0002);
    tick();
    chk("bp_next_xbar", xbar_sel, 15'h00C0);
    chk("bp_next_grant", 15'(grant), 15'h0008);
    tick();

    // Parallel outputs, input 3 selects 7 (out of range -> output 0)
    req_valid = 5'b11111;
    req_sel   = {3'd1, 3'd7, 3'd0, 3'd4, 3'd3};
    #1;
    chk("par_valid", 15'(out_valid), 15'h001B);
    chk("par_xbar", xbar_sel, 15'h1022);
    chk("par_grant", 15'(grant), 15'h0017);
    tick();
    chk("par2_xbar", xbar_sel, 15'h1023);
    chk("par2_grant", 15'(grant), 15'h001B);
    tick();

    // Request drop: ptr[4]=2, inputs 0,1 to output 4, stalled
    req_valid = 5'b00011;
    req_sel   = {3'd4, 3'd4, 3'd4, 3'd4, 3'd4};
    out_ready = 5'b01111;
    #1;
    chk("drop_valid", 15'(out_valid), 15'h0010);
    chk("drop_xbar0", xbar_sel, 15'h0000);
    req_valid = 5'b00010;
    #1;
    chk("drop_xbar1", xbar_sel, 15'h1000);
    chk("drop_grant", 15'(grant), 15'h0);
    tick();

    // Mid-run reset restores ptr[0]=0 (it was 4)
    rst_n     = 1'b0;
    req_valid = 5'b11111;
    req_sel   = '0;
    out_ready = 5'b11111;
    tick();
    rst_n = 1'b1;
    #1;
    chk("rst2_xbar", xbar_sel, 15'h0000);
    chk("rst2_grant", 15'(grant), 15'h0001);
    tick();

`ifdef PKT_LOCK_EN
    // Move ptr[1] to 1 with a single-flit transfer from input 0
    req_valid = 5'b00001;
    req_sel   = {3'd0, 3'd0, 3'd1, 3'd0, 3'd1};
    req_last  = 5'b11111;
    #1;
    chk("lk_pre_grant", 15'(grant), 15'h0001);
    tick();
    // Input 2 sends 3 flits while input 0 keeps requesting
    req_valid = 5'b00101;
    req_last  = 5'b11011;
    #1;
    chk("lk_f1", xbar_sel, 15'h0010);
    tick();
    chk("lk_f2", xbar_sel, 15'h0010);
    chk("lk_f2_grant", 15'(grant), 15'h0004);
    tick();
    req_last = 5'b11111;
    #1;
    chk("lk_f3", xbar_sel, 15'h0010);
    tick();
    req_valid = 5'b00001;
    #1;
    chk("lk_after_grant", 15'(grant), 15'h0001);
    tick();
    // Locking again, then input 2 drops mid-packet
    req_valid = 5'b00101;
    req_last  = 5'b11011;
    #1;
    chk("lk2_grant", 15'(grant), 15'h0004);
    tick();
    req_valid = 5'b00001;
    #1;
    chk("lk_drop_valid", 15'(out_valid), 15'h0);
    chk("lk_drop_grant", 15'(grant), 15'h0);
    // Reset while locked
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    chk("lk_rst_grant", 15'(grant), 15'h0001);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/switch_allocator_rr.md
# switch_allocator_rr

Round-robin switch allocator for the simple XY mesh switch. Each input port presents its head flit's output-port selection, as computed by that port's `xy_router`. Per output port, the block picks one requesting input, drives the crossbar mux select, and pops the winning input on a completed transfer. It sits between the per-input routers/FIFOs and the output crossbar of every switch configuration (CENTER, EDGE_*, SIDE_*).

## Interface
Parameters:
- `PORT_N`, default 5: number of input and output ports (3 for EDGE_*, 4 for SIDE_*, 5 for CENTER).
- `OUTPUT_N_W`, default 3: width of one port index; must satisfy 2^OUTPUT_N_W >= PORT_N.

Ports:
- `clk_i`  in  1  switch clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `req_valid_i`  in  PORT_N  input i has a head flit.
- `req_sel_i`  in  PORT_N*OUTPUT_N_W  slice i is the requested output port, i.e. `mux_out_sel_o` of input i's router.
- `req_last_i`  in  PORT_N  input i's head flit is the packet tail. Used only with `PKT_LOCK_EN`.
- `out_ready_i`  in  PORT_N  downstream of output o can accept a flit.
- `out_valid_o`  out  PORT_N  output o carries a granted flit.
- `xbar_sel_o`  out  PORT_N*OUTPUT_N_W  slice o is the input index driving output o.
- `grant_o`  out  PORT_N  input i's flit transferred this cycle; this is the pop strobe for input i.

## Operation
- **Request decoding.** Effective target of input i is `req_sel_i[i]` when it is less than PORT_N. If it is PORT_N or greater, the target is output 0 (resource), matching the router's misroute policy.
- **Per-output state.** Each output o holds:
  - `ptr[o]`, OUTPUT_N_W bits: the highest-priority input index.
  - `lock_vld[o]` and `lock_in[o]`: present only with `PKT_LOCK_EN`.
- **Arbitration.** Combinational from current state.
  - Eligible inputs for output o: valid inputs whose target is o. When locked, only `lock_in[o]` is eligible.
  - Winner: the first eligible input scanning `ptr[o]`, `ptr[o]+1`, … and wrapping modulo PORT_N. Wrap arithmetic uses PORT_N, not 2^OUTPUT_N_W.
- **Outputs.**
  - `out_valid_o[o]` = 1 iff output o has a winner.
  - `xbar_sel_o[o]` = winner index, or 0 when there is no winner.
  - A transfer on output o is `out_valid_o[o] & out_ready_i[o]`.
  - `grant_o[i]` = 1 iff input i is the winner of a transferring output.
  - Each input targets exactly one output, so at most one grant per input.
- **Pointer update.**
  - On a transfer on output o with winner w: `ptr[o] <= (w+1) mod PORT_N`.
  - With `PKT_LOCK_EN`, the pointer advances only on a transfer with `req_last_i[w]` = 1.
  - With no transfer, the pointer holds. Back-pressure never rotates priority.
- **Output independence.** Outputs arbitrate independently and in parallel; all PORT_N outputs may transfer in the same cycle.

## Timing
- Request to grant: 0 cycles, combinational.
- Pointer and lock state change only at the rising edge after a transfer.
- **Reset** (`rst_ni` low, asynchronous): `ptr` = 0, `lock_vld` = 0.
  - Outputs are then functions of inputs only. With no requests: `out_valid_o` = 0, `xbar_sel_o` = 0, `grant_o` = 0.
  - Reset asserted mid-packet drops the lock immediately.
- **Back-pressure.** `out_ready_i[o]` = 0 keeps `out_valid_o[o]` asserted and the winner stable, as long as requests are stable. `grant_o` stays 0.
- **Request drop.** An input may withdraw `req_valid_i` before a grant. The output re-arbitrates in the same cycle, except when locked.
- **Contention pattern.** A single requester wins every cycle. With every input contending for one output, each input wins once per PORT_N transfers.

## Configuration
- `PKT_LOCK_EN`, when defined:
  - A transfer with `req_last_i[w]` = 0 sets `lock_vld[o]` = 1 and `lock_in[o]` = w.
  - A transfer with `req_last_i[w]` = 1 clears the lock.
  - While locked, output o serves only `lock_in[o]`. If that input's valid drops, output o idles (`out_valid_o[o]` = 0) and is not reassigned.
  - A single-flit packet (last = 1 on the first flit) never locks.
- `PKT_LOCK_EN` undefined: lock registers are absent and `req_last_i` is ignored. Every flit arbitrates independently, giving per-flit round robin.

## Test plan
- **Reset and idle.** Hold `rst_ni` = 0, then release with all `req_valid_i` = 0 → `out_valid_o` = 0, `xbar_sel_o` = 0, `grant_o` = 0, all `ptr` = 0.
- **Fair rotation.** PORT_N = 5, inputs 0..4 all target output 0, `out_ready_i` = all 1, single-flit → winners 0,1,2,3,4,0 on consecutive cycles. `grant_o` is one-hot each cycle.
- **Back-pressure.** Inputs 1 and 3 target output 2, `ptr[2]` = 0, `out_ready_i[2]` = 0 for 3 cycles → `out_valid_o[2]` = 1, `xbar_sel_o[2]` = 1, `grant_o` = 0, pointer unchanged. Raise ready → `grant_o[1]` = 1, then `ptr[2]` = 2.
- **Parallel outputs.** Inputs 0→3, 1→4, 2→0, 4→1 all in the same cycle → four outputs valid, four grants in one cycle. An out-of-range select of 7 on input 3 → routed to output 0.
- **Packet lock** (`PKT_LOCK_EN`). Input 2 sends a 3-flit packet to output 1 while input 0 also requests output 1 → flits 2,2,2 transfer, then input 0 wins. Drop input 2's valid mid-packet → `out_valid_o[1]` = 0 and input 0 is not granted.
- **Reset mid-packet** (`PKT_LOCK_EN`). Lock held on output 1, assert `rst_ni` = 0 for 1 cycle → lock cleared, `ptr` = 0, and input 0 is granted on the next transfer.
